// File: rtl/ldpc_wb_master.sv
// Wishbone classic master that runs CSR read/write bursts of up to MAX_WORDS words
// on behalf of the LDPC control path, with per-word ack timeout and error capture.
module ldpc_wb_master #(
    parameter logic [31:0] BASE_ADR  = 32'h3001_0000,
    parameter int          MAX_WORDS = 8,
    parameter int          TIMEOUT   = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_we,
    input  logic [12:0]             i_cmd_ofs,
    input  logic [2:0]              i_cmd_len,
    input  logic [32*MAX_WORDS-1:0] i_cmd_wdata,
    output logic                    o_wb_cyc,
    output logic                    o_wb_stb,
    output logic                    o_wb_we,
    output logic [31:0]             o_wb_adr,
    output logic [31:0]             o_wb_dat,
    output logic [3:0]              o_wb_sel,
    input  logic                    i_wb_ack,
    input  logic                    i_wb_err,
    input  logic [31:0]             i_wb_dat,
    output logic [32*MAX_WORDS-1:0] o_rdata,
    output logic                    o_done,
    output logic                    o_err,
    output logic                    o_tmo
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    rdy_q;
    logic                    cyc_q;
    logic                    wbwe_q;
    logic [31:0]             adr_q;
    logic [31:0]             dat_q;
    logic [3:0]              sel_q;
    logic [32*MAX_WORDS-1:0] rdata_q;
    logic                    done_q;
    logic                    err_q;
    logic                    tmo_q;
    logic                    we_q;
    logic [2:0]              len_q;
    logic [2:0]              idx_q;
    logic [2:0]              idx_d;
    logic [CW-1:0]           wait_q;
    logic [CW-1:0]           wait_d;
    logic [32*MAX_WORDS-1:0] wdata_q;
    logic                    last_word;
    logic                    timed_out;
    logic                    end_burst;
    logic                    unused_ofs;

    // Command handshake: a command transfers on a rising edge where i_cmd_valid and
    // o_cmd_ready are both high; o_cmd_ready is registered and is only ever high in IDLE.

    assign unused_ofs = ^i_cmd_ofs[1:0];

    assign idx_d     = idx_q + 3'd1;
    assign wait_d    = wait_q + CW'(1);
    assign last_word = (idx_q == len_q);
    assign timed_out = (wait_q == CW'(TIMEOUT));
    assign end_burst = (state_q == ST_BUS) &&
                       (i_wb_err || (i_wb_ack && last_word) || (!i_wb_ack && timed_out));

    function automatic logic [31:0] word_sel(input logic [32*MAX_WORDS-1:0] vec,
                                             input logic [2:0] idx);
        word_sel = '0;
        for (int k = 0; k < MAX_WORDS; k++) begin
            if (int'(idx) == k) word_sel = vec[32*k +: 32];
        end
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
            cyc_q   <= 1'b0;
            wbwe_q  <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            we_q    <= 1'b0;
            len_q   <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            wdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    rdy_q <= 1'b1;
                    if (i_cmd_valid && rdy_q) begin
                        we_q    <= i_cmd_we;
                        len_q   <= i_cmd_len;
                        wdata_q <= i_cmd_wdata;
                        idx_q   <= '0;
                        wait_q  <= '0;
                        err_q   <= 1'b0;
                        tmo_q   <= 1'b0;
                        if (!i_cmd_we) rdata_q <= '0;
                        rdy_q   <= 1'b0;
                        cyc_q   <= 1'b1;
                        wbwe_q  <= i_cmd_we;
                        adr_q   <= BASE_ADR + {19'b0, i_cmd_ofs[12:2], 2'b00};
                        dat_q   <= i_cmd_we ? i_cmd_wdata[31:0] : 32'd0;
                        sel_q   <= 4'hF;
                        state_q <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // err takes priority over a simultaneous ack and discards that word.
                    if (i_wb_err) begin
                        err_q <= 1'b1;
                    end else if (i_wb_ack) begin
                        wait_q <= '0;
                        if (!we_q) begin
                            for (int k = 0; k < MAX_WORDS; k++) begin
                                if (int'(idx_q) == k) rdata_q[32*k +: 32] <= i_wb_dat;
                            end
                        end
                        if (!last_word) begin
                            idx_q <= idx_d;
                            adr_q <= adr_q + 32'd4;
                            dat_q <= we_q ? word_sel(wdata_q, idx_d) : 32'd0;
                        end
                    end else if (timed_out) begin
                        tmo_q <= 1'b1;
                    end else begin
                        wait_q <= wait_d;
                    end
                    if (end_burst) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        cyc_q   <= 1'b0;
                        wbwe_q  <= 1'b0;
                        adr_q   <= '0;
                        dat_q   <= '0;
                        sel_q   <= '0;
                    end
                end
                ST_DONE: begin
                    rdy_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready = rdy_q;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = cyc_q;
    assign o_wb_we     = wbwe_q;
    assign o_wb_adr    = adr_q;
    assign o_wb_dat    = dat_q;
    assign o_wb_sel    = sel_q;
    assign o_rdata     = rdata_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_tmo       = tmo_q;

endmodule

// File: tb/tb_ldpc_wb_master.sv
// Bench for ldpc_wb_master: directed vector table, randomized bursts against a
// transaction-level model, and hand sequences for reset and back-to-back commands.
module tb_ldpc_wb_master;

    localparam int          MW   = 8;
    localparam int          TMO  = 255;
    localparam logic [31:0] BASE = 32'h3001_0000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic           cmd_we = 1'b0;
    logic [12:0]    cmd_ofs = '0;
    logic [2:0]     cmd_len = '0;
    logic [255:0]   cmd_wdata = '0;
    logic           wb_cyc, wb_stb, wb_we;
    logic [31:0]    wb_adr, wb_dat_o;
    logic [3:0]     wb_sel;
    logic           wb_ack = 1'b0;
    logic           wb_err = 1'b0;
    logic [31:0]    wb_dat_i = '0;
    logic [255:0]   rdata;
    logic           done, err, tmo;

    ldpc_wb_master #(.BASE_ADR(BASE), .MAX_WORDS(MW), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
        .i_cmd_ofs(cmd_ofs), .i_cmd_len(cmd_len), .i_cmd_wdata(cmd_wdata),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_adr(wb_adr),
        .o_wb_dat(wb_dat_o), .o_wb_sel(wb_sel), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
        .i_wb_dat(wb_dat_i), .o_rdata(rdata), .o_done(done), .o_err(err), .o_tmo(tmo)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int           n_pass = 0;
    int           n_total = 0;
    logic [64:0]  exp_q[$];     // {adr, we, dat} per expected bus access
    logic [64:0]  obs_q[$];
    logic [31:0]  rd_words[8];
    logic [255:0] rd_hold = '0;
    int           done_edge;
    bit           bus_ok;

    typedef struct {
        logic        we;
        logic [12:0] ofs;
        logic [2:0]  len;
        int          wait_all;
        int          err_word;
        logic [31:0] rd_fixed;
        int          exp_done;
        int          exp_nacc;
        logic [31:0] exp_adr_first;
        logic [31:0] exp_adr_last;
        logic        exp_err;
        logic        exp_tmo;
    } vec_t;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level expectation straight from the burst rules.
    task automatic model(input logic we, input logic [12:0] ofs, input logic [2:0] len,
                         input logic [255:0] wd, input int waits[8], input int err_word,
                         output int cyc_n, output logic e_err, output logic e_tmo,
                         output logic [255:0] e_rd);
        logic [31:0] a;
        exp_q.delete();
        cyc_n = 0;
        e_err = 1'b0;
        e_tmo = 1'b0;
        e_rd  = we ? rd_hold : '0;
        for (int k = 0; k <= int'(len); k++) begin
            a = BASE + {19'b0, ofs[12:2], 2'b00} + 32'(4 * k);
            if (waits[k] > TMO) begin
                e_tmo = 1'b1;
                cyc_n += TMO + 1;
                break;
            end
            cyc_n += waits[k] + 1;
            exp_q.push_back({a, we, we ? wd[32*k +: 32] : 32'd0});
            if (k == err_word) begin
                e_err = 1'b1;
                break;
            end
            if (!we) e_rd[32*k +: 32] = rd_words[k];
        end
    endtask

    // Issues one command and acts as the Wishbone responder until o_done.
    task automatic run_burst(input logic we, input logic [12:0] ofs, input logic [2:0] len,
                             input logic [255:0] wd, input int waits[8], input int err_word);
        int wi;
        int wc;
        obs_q.delete();
        done_edge = -1;
        bus_ok = 1'b1;
        for (int i = 0; i < 4 && !cmd_ready; i++) tick();
        cmd_valid = 1'b1;
        cmd_we = we;
        cmd_ofs = ofs;
        cmd_len = len;
        cmd_wdata = wd;
        wb_ack = 1'b0;
        wb_err = 1'b0;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < MW; k++) cmd_wdata[32*k +: 32] = $urandom;
        wi = 0;
        wc = 0;
        for (int e = 0; e < 1200; e++) begin
            if (done) begin
                done_edge = e;
                break;
            end
            if (wb_cyc) begin
                if (!wb_stb || wb_sel != 4'hF || wb_we !== we) bus_ok = 1'b0;
                if (wi < 8 && waits[wi] <= TMO && wc == waits[wi]) begin
                    wb_ack = 1'b1;
                    wb_err = (wi == err_word);
                    wb_dat_i = rd_words[wi];
                    obs_q.push_back({wb_adr, wb_we, wb_dat_o});
                    wi++;
                    wc = 0;
                end else begin
                    wb_ack = 1'b0;
                    wb_err = 1'b0;
                    wb_dat_i = $urandom;
                    wc++;
                end
            end else begin
                if (wb_we || wb_adr != 0 || wb_dat_o != 0 || wb_sel != 0) bus_ok = 1'b0;
                wb_ack = 1'b0;
                wb_err = 1'b0;
            end
            tick();
        end
        wb_ack = 1'b0;
        wb_err = 1'b0;
    endtask

    task automatic do_burst(input string tag, input logic we, input logic [12:0] ofs,
                            input logic [2:0] len, input logic [255:0] wd,
                            input int waits[8], input int err_word);
        int           cyc_n;
        logic         e_err, e_tmo;
        logic [255:0] e_rd;
        model(we, ofs, len, wd, waits, err_word, cyc_n, e_err, e_tmo, e_rd);
        run_burst(we, ofs, len, wd, waits, err_word);
        check({tag, "_done_edge"}, 256'(done_edge), 256'(cyc_n));
        check({tag, "_n_acc"}, 256'(obs_q.size()), 256'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_acc%0d", tag, i), 256'(obs_q[i]), 256'(exp_q[i]));
        check({tag, "_err"}, 256'(err), 256'(e_err));
        check({tag, "_tmo"}, 256'(tmo), 256'(e_tmo));
        check({tag, "_rdata"}, rdata, e_rd);
        check({tag, "_bus_signals"}, 256'(bus_ok), 256'(1));
        // Stray responder activity in the following IDLE cycle must be ignored.
        wb_ack = 1'($urandom_range(0, 1));
        wb_err = 1'($urandom_range(0, 1));
        wb_dat_i = $urandom;
        tick();
        check({tag, "_done_single"}, 256'(done), 256'(0));
        check({tag, "_ready_again"}, 256'(cmd_ready), 256'(1));
        check({tag, "_rdata_hold"}, rdata, e_rd);
        wb_ack = 1'b0;
        wb_err = 1'b0;
        rd_hold = e_rd;
    endtask

    vec_t vecs[7];

    initial begin
        int           waits[8];
        logic [255:0] wd;
        logic         we;
        logic [12:0]  ofs;
        logic [2:0]   len;
        int           ew;
        logic [7:0]   cyc_bits, done_bits, rdy_bits;
        bit           any_bad;

        vecs[0] = '{1'b1, 13'h0010, 3'd2, 0,   -1, 32'h0,         3,   3, 32'h3001_0010, 32'h3001_0018, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 13'h0000, 3'd0, 3,   -1, 32'hDEAD_BEEF, 4,   1, 32'h3001_0000, 32'h3001_0000, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 13'h0020, 3'd3, 0,    1, 32'h0,         2,   2, 32'h3001_0020, 32'h3001_0024, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 13'h0000, 3'd0, 300, -1, 32'h0,         256, 0, 32'h0,         32'h0,         1'b0, 1'b1};
        vecs[4] = '{1'b1, 13'h1FFF, 3'd7, 1,   -1, 32'h0,         16,  8, 32'h3001_1FFC, 32'h3001_2018, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 13'h0004, 3'd1, 255, -1, 32'h0,         512, 2, 32'h3001_0004, 32'h3001_0008, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 13'h0100, 3'd1, 0,    0, 32'h0,         1,   1, 32'h3001_0100, 32'h3001_0100, 1'b1, 1'b0};

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #2;
        check("rst_cyc", 256'(wb_cyc), 256'(0));
        check("rst_ready", 256'(cmd_ready), 256'(0));
        check("rst_adr", 256'(wb_adr), 256'(0));
        check("rst_outs", 256'({done, err, tmo, wb_sel}), 256'(0));
        check("rst_rdata", rdata, 256'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        check("ready_after_rst", 256'(cmd_ready), 256'(1));

        // Directed vector table.
        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < 8; k++) begin
                waits[k] = vecs[v].wait_all;
                rd_words[k] = (vecs[v].rd_fixed != 0) ? vecs[v].rd_fixed : $urandom;
                wd[32*k +: 32] = $urandom;
            end
            do_burst($sformatf("vec%0d", v), vecs[v].we, vecs[v].ofs, vecs[v].len, wd,
                     waits, vecs[v].err_word);
            check($sformatf("vec%0d_tbl_done", v), 256'(done_edge), 256'(vecs[v].exp_done));
            check($sformatf("vec%0d_tbl_nacc", v), 256'(obs_q.size()), 256'(vecs[v].exp_nacc));
            if (vecs[v].exp_nacc > 0) begin
                check($sformatf("vec%0d_tbl_adr_first", v), 256'(obs_q[0][64:33]),
                      256'(vecs[v].exp_adr_first));
                check($sformatf("vec%0d_tbl_adr_last", v), 256'(obs_q[obs_q.size()-1][64:33]),
                      256'(vecs[v].exp_adr_last));
            end
            check($sformatf("vec%0d_tbl_err", v), 256'(err), 256'(vecs[v].exp_err));
            check($sformatf("vec%0d_tbl_tmo", v), 256'(tmo), 256'(vecs[v].exp_tmo));
            if (vecs[v].rd_fixed != 0)
                check($sformatf("vec%0d_tbl_rword0", v), 256'(rdata[31:0]), 256'(vecs[v].rd_fixed));
        end

        // Randomized bursts against the model.
        for (int r = 0; r < 25; r++) begin
            we  = 1'($urandom_range(0, 1));
            ofs = 13'($urandom);
            len = 3'($urandom_range(0, 7));
            for (int k = 0; k < 8; k++) begin
                waits[k] = $urandom_range(0, 3);
                rd_words[k] = $urandom;
                wd[32*k +: 32] = $urandom;
            end
            if ($urandom_range(0, 9) == 0) waits[$urandom_range(0, int'(len))] = 300;
            ew = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(len))) : -1;
            do_burst($sformatf("rnd%0d", r), we, ofs, len, wd, waits, ew);
        end

        // Reset asserted while word 1 of a read burst is on the bus.
        for (int i = 0; i < 4 && !cmd_ready; i++) tick();
        cmd_valid = 1'b1;
        cmd_we = 1'b0;
        cmd_ofs = 13'h0040;
        cmd_len = 3'd3;
        tick();
        cmd_valid = 1'b0;
        wb_ack = 1'b1;
        wb_dat_i = 32'h1234_5678;
        tick();
        wb_ack = 1'b0;
        check("mid_word1_adr", 256'(wb_adr), 256'(32'h3001_0044));
        check("mid_word1_cyc", 256'(wb_cyc), 256'(1));
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_cyc_async", 256'({wb_cyc, wb_stb}), 256'(0));
        check("mid_rst_adr", 256'(wb_adr), 256'(0));
        check("mid_rst_rdata", rdata, 256'(0));
        check("mid_rst_flags", 256'({done, err, tmo, cmd_ready}), 256'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        check("mid_ready_after_rel", 256'(cmd_ready), 256'(1));
        any_bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wb_ack = 1'($urandom_range(0, 1));
            wb_err = 1'($urandom_range(0, 1));
            wb_dat_i = $urandom;
            tick();
            if (done || wb_cyc || err || tmo || rdata != 0) any_bad = 1'b1;
        end
        check("mid_no_done_after_rst", 256'(any_bad), 256'(0));
        rd_hold = '0;

        // Spurious acks in IDLE, then one command held valid across two bursts.
        wb_ack = 1'b1;
        wb_err = 1'b0;
        wb_dat_i = 32'hFFFF_FFFF;
        tick();
        check("idle_ack_ignored", 256'({wb_cyc, done, err, tmo}), 256'(0));
        check("idle_ack_rdata", rdata, 256'(0));
        wb_ack = 1'b0;
        cmd_valid = 1'b1;
        cmd_we = 1'b1;
        cmd_ofs = 13'h0008;
        cmd_len = 3'd1;
        for (int k = 0; k < MW; k++) cmd_wdata[32*k +: 32] = $urandom;
        cyc_bits = '0;
        done_bits = '0;
        rdy_bits = '0;
        for (int s = 0; s < 8; s++) begin
            tick();
            cyc_bits[s]  = wb_cyc;
            done_bits[s] = done;
            rdy_bits[s]  = cmd_ready;
            wb_ack = wb_cyc;
            if (s == 7) cmd_valid = 1'b0;
        end
        wb_ack = 1'b0;
        check("b2b_cyc_pattern", 256'(cyc_bits), 256'(8'h33));
        check("b2b_done_pattern", 256'(done_bits), 256'(8'h44));
        check("b2b_ready_pattern", 256'(rdy_bits), 256'(8'h88));
        tick();
        tick();
        check("b2b_no_third", 256'({wb_cyc, done, err, tmo}), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ldpc_wb_master.md
LDPC_WB_MASTER -- requirements
Module: ldpc_wb_master

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h3001_0000: CSR window base; the word address is BASE_ADR + offset.
REQ-002 SHALL have parameter MAX_WORDS, default 8: maximum burst length in 32-bit words.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for ack per word.
REQ-004 Ports, in this order:
- i_clk  in  1  sole clock; all logic is on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  high only in IDLE.
- i_cmd_we  in  1  1 = write burst, 0 = read burst.
- i_cmd_ofs  in  13  byte offset of the first word; bits [1:0] are ignored.
- i_cmd_len  in  3  word count minus 1 (0..7).
- i_cmd_wdata  in  32*MAX_WORDS  write words; word k is at [32k+31:32k].
- o_wb_cyc, o_wb_stb  out  1 each  Wishbone classic cycle and strobe.
- o_wb_we  out  1  write enable.
- o_wb_adr  out  32  word address.
- o_wb_dat  out  32  write data.
- o_wb_sel  out  4  byte select, always 4'hF during a transfer.
- i_wb_ack  in  1  responder acknowledge.
- i_wb_err  in  1  responder error.
- i_wb_dat  in  32  read data.
- o_rdata  out  32*MAX_WORDS  collected read words; word k is at [32k+31:32k].
- o_done  out  1  one-cycle burst completion pulse.
- o_err  out  1  error status of the last burst.
- o_tmo  out  1  timeout status of the last burst.

Function
REQ-005 SHALL implement the FSM states IDLE, BUS and DONE.
REQ-006 IDLE: when i_cmd_valid && o_cmd_ready, SHALL perform the following, then go to BUS on the next edge:
- latch we, len, ofs[12:2] and wdata;
- clear the word index, o_err and o_tmo;
- clear o_rdata when we = 0.
REQ-007 In BUS, o_wb_cyc and o_wb_stb SHALL both be 1, and SHALL be registered.
REQ-008 In BUS, o_wb_adr SHALL equal BASE_ADR + {ofs[12:2], 2'b00} + 4*index, with 32-bit wrap-around.
REQ-009 In BUS, o_wb_dat SHALL equal wdata word[index] for writes and 0 for reads.
REQ-010 In BUS, on i_wb_ack=1 and i_wb_err=0, for a read SHALL capture i_wb_dat into o_rdata word[index] in the same edge.
REQ-011 On that ack, if index==len SHALL go to DONE and drop cyc/stb; otherwise SHALL increment the index, keep cyc/stb high and present the next address/data on the following cycle (back-to-back, no idle gap).
REQ-012 In BUS, i_wb_err=1 SHALL set o_err and go to DONE, even if ack is high in the same cycle (err wins); remaining words are abandoned.
REQ-013 A per-word wait counter SHALL clear on entry to BUS and on every ack, and increment every BUS cycle without ack or err.
REQ-014 When the wait counter reaches TIMEOUT with no ack or err, SHALL set o_tmo and go to DONE.
REQ-015 DONE: o_done=1 for exactly one cycle; SHALL return to IDLE on the next edge.
REQ-016 o_err, o_tmo and o_rdata SHALL hold until the next command is accepted.
REQ-017 SHALL ignore i_wb_ack, i_wb_err and i_wb_dat outside BUS.
REQ-018 SHALL never accept a command outside IDLE; i_cmd_valid held high through DONE is accepted in the cycle after DONE.
REQ-019 Outside BUS, o_wb_we, o_wb_adr, o_wb_dat and o_wb_sel SHALL be 0.
REQ-020 Latency for a burst of len+1 words with zero-wait acks SHALL be: accept edge, then len+1 BUS cycles, then 1 DONE cycle.

Reset
REQ-021 i_rst_n=0 SHALL asynchronously force the following, regardless of state, including mid-burst:
- FSM to IDLE;
- all outputs to 0, except o_cmd_ready=1 after reset release;
- the wait counter and index to 0.
REQ-022 The first command SHALL be accepted no earlier than the first rising edge after i_rst_n goes high.

Verification
REQ-023 Write, len=2, ofs=13'h0010, zero-wait acks -> three BUS cycles on o_wb_adr:
- 32'h3001_0010, 32'h3001_0014, 32'h3001_0018, with we=1 and sel=4'hF;
- o_done on cycle 4;
- o_err=0 and o_tmo=0.
REQ-024 Read, len=0, ack after 3 wait cycles with i_wb_dat=32'hDEAD_BEEF -> o_rdata[31:0]=32'hDEAD_BEEF and a single o_done pulse.
REQ-025 Read, len=3, i_wb_err on word 1 with ack also high -> o_err=1, o_done pulses, word 1 not captured, and no access to words 2-3.
REQ-026 No ack, TIMEOUT=255 -> o_tmo=1 and o_done exactly 256 cycles after the accept edge.
REQ-027 i_rst_n pulsed low mid-burst at word 1 -> o_wb_cyc=0 immediately (asynchronously), o_cmd_ready=1 after release, and no o_done.
REQ-028 Spurious i_wb_ack in IDLE plus a back-to-back command held high -> ack ignored, and the second burst starts in the cycle after DONE.
